tc0_count_unit: RTL
===================

Name: tc0_count_unit

Overview:
- Timer/Counter0 counting core; sits directly downstream of the Timer0 prescaler and consumes its clk8en/clk64en/clk256en/clk1024en strobes.
- Selects one count-enable source per CS0 (stop, clk/1, prescaled, or external T0 pin edge).
- Drives the 8-bit TCNT0 register in Normal or CTC mode.
- Raises TOV0, OCF0A and OCF0B flags for the interrupt/register-file logic.

Parameters:
- WIDTH, 8, counter and compare register width (fixed at 8 for TC0; parameterised for reuse in TC2).
- SYNC_STAGES, 2, number of synchroniser flops on t0_pin before edge detection (minimum 2).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clk8en  in  1  prescaler strobe, one clk wide, every 8 clocks
- clk64en  in  1  prescaler strobe, every 64 clocks
- clk256en  in  1  prescaler strobe, every 256 clocks
- clk1024en  in  1  prescaler strobe, every 1024 clocks
- cs  in  3  clock select: 0 stop, 1 clk/1, 2 /8, 3 /64, 4 /256, 5 /1024, 6 T0 falling edge, 7 T0 rising edge
- ctc  in  1  1 = CTC mode (TOP = ocra), 0 = Normal mode (TOP = 0xFF)
- t0_pin  in  1  asynchronous external clock pin
- ocra  in  WIDTH  compare value A
- ocrb  in  WIDTH  compare value B
- tcnt_we  in  1  CPU write strobe to TCNT0
- tcnt_wdata  in  WIDTH  CPU write data
- flag_clr  in  3  write-one-to-clear: [0] tov, [1] ocfa, [2] ocfb
- tcnt  out  WIDTH  current counter value
- tick  out  1  selected count enable (for debug/OC-pin logic)
- tov  out  1  overflow flag
- ocfa  out  1  compare-A match flag
- ocfb  out  1  compare-B match flag

Behaviour:
- Reset (synchronous, active-high): tcnt=0, tov=ocfa=ocfb=0, synchroniser and edge flops=0, cmp_block=0. The output tick is combinational and is 0 while cs=0.
- tick is combinational from cs:
  - cs=0: 0
  - cs=1: 1
  - cs=2..5: the matching clk*en input
  - cs=6: fall = s_prev & ~s_sync
  - cs=7: rise = ~s_prev & s_sync
- External path: t0_pin passes through SYNC_STAGES flops to give s_sync; s_prev is s_sync delayed by one clock. A t0_pin transition first sampled at edge N moves tcnt at edge N+SYNC_STAGES, i.e. the 3rd edge for the default of 2.
- Changing cs takes effect the same cycle. Synchroniser flops run regardless of cs.
- Counter update, priority high to low:
  1. tcnt_we: tcnt = tcnt_wdata, no increment, cmp_block = 1.
  2. tick && ctc && tcnt == ocra: tcnt = 0.
  3. tick: tcnt = tcnt + 1, modulo 2^WIDTH (0xFF wraps to 0x00).
  4. Otherwise hold.
- cmp_block is cleared on the next tick that is not accompanied by tcnt_we.
- Flag set conditions, evaluated on the pre-update tcnt and only when tick=1, tcnt_we=0 and cmp_block=0 (the cmp_block qualifier applies to the compare flags):
  - ocfa when tcnt == ocra
  - ocfb when tcnt == ocrb
  - tov when tcnt == 0xFF and the next value is 0x00. In CTC mode this happens only if ocra == 0xFF.
- Flags are sticky and are cleared by flag_clr[i] at the next edge. If set and clear occur in the same cycle, set wins.
- tcnt_we does not suppress tov. Overflow is impossible in a write cycle because no increment occurs.
- Compare values are read live; there is no double buffering (Normal/CTC only).
- A CTC match with ocra=0 holds tcnt at 0 and sets ocfa on every tick.
- Reset mid-count returns to the reset state at the next edge; in-flight synchroniser edges are discarded.

Decomposition:
- tc0_pkg holds:
  - cs encodings CS_STOP, CS_DIV1, CS_DIV8, CS_DIV64, CS_DIV256, CS_DIV1024, CS_EXT_FALL, CS_EXT_RISE
  - flag index constants FLG_TOV=0, FLG_OCFA=1, FLG_OCFB=2
  - TOP_MAX = 8'hFF
- One sub-module, tc0_clk_sel, contains the cs mux plus the T0 synchroniser/edge detector and outputs tick.
- tc0_count_unit instantiates tc0_clk_sel and implements counter, cmp_block and flags.

Test Plan:
- Reset; cs=1, ctc=0, ocra=0x10, ocrb=0x20; run 300 clocks. Expect tcnt increments every clock and ocfa set on the edge leaving 0x10. Expect ocfb set on the edge leaving 0x20, and tov set on the 256th tick (0xFF->0x00) and held.
- cs=3 with the prescaler running: tcnt advances exactly once per clk64en pulse. Switch to cs=0: tcnt frozen and flags unchanged for 200 clocks.
- cs=1, ctc=1, ocra=0x05: tcnt sequence 0,1,2,3,4,5,0,... with ocfa set on each 5->0 transition and tov never set. Repeat with ocra=0x00: tcnt stuck at 0 and ocfa set.
- cs=7: toggle t0_pin 0->1 sampled at edge N. Expect tcnt+1 at edge N+2, and no count on 1->0. Under cs=6, the count happens on the 1->0 transition only.
- tcnt_we writes 0x10 while ocra=0x10 and cs=1. Expect no ocfa on the next tick (cmp_block); tcnt reaches 0x11 with no flag, and ocfa fires on the next wrap pass through 0x10.
- ocfa set and flag_clr[1]=1 in the same cycle as a new match: ocfa remains 1. flag_clr[1] alone in a later cycle clears ocfa to 0; flag_clr=3'b111 clears all flags.

Source files
------------

// File: rtl/tc0_pkg.sv
// Shared encodings for the Timer/Counter0 counting core: clock-select codes,
// flag bit positions and the Normal-mode TOP value.
package tc0_pkg;

  typedef enum logic [2:0] {
    CS_STOP     = 3'd0,
    CS_DIV1     = 3'd1,
    CS_DIV8     = 3'd2,
    CS_DIV64    = 3'd3,
    CS_DIV256   = 3'd4,
    CS_DIV1024  = 3'd5,
    CS_EXT_FALL = 3'd6,
    CS_EXT_RISE = 3'd7
  } cs_e;

  localparam int FLG_TOV  = 0;
  localparam int FLG_OCFA = 1;
  localparam int FLG_OCFB = 2;

  localparam logic [7:0] TOP_MAX = 8'hFF;

endpackage

// File: rtl/tc0_clk_sel.sv
// Count-enable selection for TC0: picks a prescaler strobe or a synchronised
// edge of the external T0 pin according to cs.
module tc0_clk_sel
  import tc0_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk8en,
  input  logic       clk64en,
  input  logic       clk256en,
  input  logic       clk1024en,
  input  logic [2:0] cs,
  input  logic       t0_pin,
  output logic       tick
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_prev;
  logic                   s_sync;
  logic                   rise;
  logic                   fall;

  // The synchroniser runs regardless of cs so a later switch to an external
  // source sees a settled pin rather than a spurious edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      s_prev <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], t0_pin};
      s_prev <= s_sync;
    end
  end

  assign s_sync = sync_q[SYNC_STAGES-1];
  assign rise   = ~s_prev & s_sync;
  assign fall   = s_prev & ~s_sync;

  always_comb begin
    tick = 1'b0;
    case (cs_e'(cs))
      CS_STOP:     tick = 1'b0;
      CS_DIV1:     tick = 1'b1;
      CS_DIV8:     tick = clk8en;
      CS_DIV64:    tick = clk64en;
      CS_DIV256:   tick = clk256en;
      CS_DIV1024:  tick = clk1024en;
      CS_EXT_FALL: tick = fall;
      CS_EXT_RISE: tick = rise;
      default:     tick = 1'b0;
    endcase
  end

endmodule

// File: rtl/tc0_count_unit.sv
// Timer/Counter0 counting core: TCNT0 in Normal or CTC mode with sticky
// TOV0/OCF0A/OCF0B flags, fed by the count enable from tc0_clk_sel.
module tc0_count_unit
  import tc0_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk8en,
  input  logic             clk64en,
  input  logic             clk256en,
  input  logic             clk1024en,
  input  logic [2:0]       cs,
  input  logic             ctc,
  input  logic             t0_pin,
  input  logic [WIDTH-1:0] ocra,
  input  logic [WIDTH-1:0] ocrb,
  input  logic             tcnt_we,
  input  logic [WIDTH-1:0] tcnt_wdata,
  input  logic [2:0]       flag_clr,
  output logic [WIDTH-1:0] tcnt,
  output logic             tick,
  output logic             tov,
  output logic             ocfa,
  output logic             ocfb
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] tcnt_next;
  logic             cmp_block;
  logic             count_ok;
  logic             set_tov;
  logic             set_ocfa;
  logic             set_ocfb;

  tc0_clk_sel #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_clk_sel (
    .clk       (clk),
    .reset     (reset),
    .clk8en    (clk8en),
    .clk64en   (clk64en),
    .clk256en  (clk256en),
    .clk1024en (clk1024en),
    .cs        (cs),
    .t0_pin    (t0_pin),
    .tick      (tick)
  );

  always_comb begin
    tcnt_next = tcnt;
    if (tcnt_we)
      tcnt_next = tcnt_wdata;
    else if (tick && ctc && (tcnt == ocra))
      tcnt_next = '0;
    else if (tick)
      tcnt_next = tcnt + WIDTH'(1);
  end

  // A CPU write blocks compare matches until the next genuine count, so
  // writing the compare value itself does not raise a flag.
  assign count_ok = tick & ~tcnt_we;
  assign set_ocfa = count_ok & ~cmp_block & (tcnt == ocra);
  assign set_ocfb = count_ok & ~cmp_block & (tcnt == ocrb);
  assign set_tov  = count_ok & (tcnt == CNT_MAX) & (tcnt_next == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt      <= '0;
      cmp_block <= 1'b0;
      tov       <= 1'b0;
      ocfa      <= 1'b0;
      ocfb      <= 1'b0;
    end else begin
      tcnt <= tcnt_next;
      if (tcnt_we)
        cmp_block <= 1'b1;
      else if (tick)
        cmp_block <= 1'b0;
      tov  <= set_tov  | (tov  & ~flag_clr[FLG_TOV]);
      ocfa <= set_ocfa | (ocfa & ~flag_clr[FLG_OCFA]);
      ocfb <= set_ocfb | (ocfb & ~flag_clr[FLG_OCFB]);
    end
  end

endmodule
